// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the exception vector used by the PC-select logic.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_PRID   = 5'd15;

    localparam int unsigned IM_LSB      = 10;
    localparam int unsigned IP_LSB      = 10;
    localparam int unsigned EXL_BIT     = 1;
    localparam int unsigned IE_BIT      = 0;
    localparam int unsigned EXCCODE_LSB = 2;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_BP  = 5'd9,
        EXC_RI  = 5'd10
    } exc_code_e;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0800;

endpackage

// File: rtl/cp0_exc_ctrl_int_sync.sv
// Multi-stage flop synchroniser for asynchronous level inputs.
module int_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= async_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status, Cause, EPC, PRId, interrupt
// synchronisation, exception decision and mtc0/mfc0/eret servicing.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE  = 32'h0000_0001,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  IntReq,
    input  logic        SwExc,
    input  logic [4:0]  SwExcCode,
    input  logic        IsEretCond,
    input  logic        Mtc0We,
    input  logic [4:0]  Cp0Addr,
    input  logic [31:0] Cp0WData,
    input  logic [31:0] PresentPC,
    output logic [31:0] Cp0RData,
    output logic        HasExp,
    output logic [31:0] EPC,
    output logic        Exl
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic [4:0]  exccode_q;
    logic [31:0] epc_q;
    logic [5:0]  ip;
    logic        int_pend;

    int_sync #(
        .WIDTH  (6),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (IntReq),
        .sync_o  (ip)
    );

    assign int_pend = ie_q & ~exl_q & (|(ip & im_q));
    assign HasExp   = ~exl_q & (SwExc | int_pend);
    assign EPC      = epc_q;
    assign Exl      = exl_q;

    // Exception entry outranks eret and mtc0 from the same instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else if (HasExp) begin
            epc_q     <= PresentPC;
            exccode_q <= SwExc ? SwExcCode : EXC_INT;
            exl_q     <= 1'b1;
        end else if (IsEretCond && exl_q) begin
            exl_q <= 1'b0;
        end else if (Mtc0We) begin
            case (Cp0Addr)
                CP0_STATUS: begin
                    im_q  <= Cp0WData[IM_LSB +: 6];
                    exl_q <= Cp0WData[EXL_BIT];
                    ie_q  <= Cp0WData[IE_BIT];
                end
                CP0_CAUSE: exccode_q <= Cp0WData[EXCCODE_LSB +: 5];
                CP0_EPC:   epc_q     <= Cp0WData;
                default: ;
            endcase
        end
    end

    always_comb begin
        Cp0RData = '0;
        case (Cp0Addr)
            CP0_STATUS: begin
                Cp0RData[IM_LSB +: 6] = im_q;
                Cp0RData[EXL_BIT]     = exl_q;
                Cp0RData[IE_BIT]      = ie_q;
            end
            CP0_CAUSE: begin
                Cp0RData[IP_LSB +: 6]      = ip;
                Cp0RData[EXCCODE_LSB +: 5] = exccode_q;
            end
            CP0_EPC:  Cp0RData = epc_q;
            CP0_PRID: Cp0RData = PRID_VALUE;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl with hand-computed expectations.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  IntReq;
    logic        SwExc;
    logic [4:0]  SwExcCode;
    logic        IsEretCond;
    logic        Mtc0We;
    logic [4:0]  Cp0Addr;
    logic [31:0] Cp0WData;
    logic [31:0] PresentPC;
    logic [31:0] Cp0RData;
    logic        HasExp;
    logic [31:0] EPC;
    logic        Exl;

    int unsigned vectors;
    int unsigned miscompares;

    cp0_exc_ctrl #(
        .PRID_VALUE  (32'h0000_0001),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .IntReq     (IntReq),
        .SwExc      (SwExc),
        .SwExcCode  (SwExcCode),
        .IsEretCond (IsEretCond),
        .Mtc0We     (Mtc0We),
        .Cp0Addr    (Cp0Addr),
        .Cp0WData   (Cp0WData),
        .PresentPC  (PresentPC),
        .Cp0RData   (Cp0RData),
        .HasExp     (HasExp),
        .EPC        (EPC),
        .Exl        (Exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        Cp0Addr = a;
        #1;
        check(tag, Cp0RData, exp);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        IntReq = '0; SwExc = 1'b0; SwExcCode = '0; IsEretCond = 1'b0;
        Mtc0We = 1'b0; Cp0Addr = '0; Cp0WData = '0; PresentPC = '0;
        #1;
        check("rst_hasexp", {31'd0, HasExp}, 32'd0);
        check("rst_exl", {31'd0, Exl}, 32'd0);
        check("rst_epc", EPC, 32'd0);
        rd(5'd12, "rst_status", 32'd0);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epcreg", 32'd0);
        rd(5'd15, "prid", 32'h0000_0001);
        tick();
        rst = 1'b0;

        // Status = IM0 | IE
        Mtc0We = 1'b1; Cp0Addr = 5'd12; Cp0WData = 32'h0000_0401;
        tick();
        Mtc0We = 1'b0;
        rd(5'd12, "status_wr", 32'h0000_0401);

        // Interrupt latency: two edges through the synchroniser
        IntReq = 6'b000001; PresentPC = 32'h0000_0040;
        #1;
        check("int_lat0", {31'd0, HasExp}, 32'd0);
        tick();
        check("int_lat1", {31'd0, HasExp}, 32'd0);
        tick();
        check("int_lat2", {31'd0, HasExp}, 32'd1);
        tick();
        check("int_epc", EPC, 32'h0000_0040);
        check("int_exl", {31'd0, Exl}, 32'd1);
        check("int_hasexp_off", {31'd0, HasExp}, 32'd0);
        rd(5'd13, "int_cause", 32'h0000_0400);

        // mtc0 EPC inside the handler, then eret
        Mtc0We = 1'b1; Cp0Addr = 5'd14; Cp0WData = 32'h0000_0104;
        tick();
        Mtc0We = 1'b0;
        check("epc_mtc0", EPC, 32'h0000_0104);
        IsEretCond = 1'b1; PresentPC = 32'h0000_0900;
        #1;
        check("eret_epc_out", EPC, 32'h0000_0104);
        check("eret_hasexp", {31'd0, HasExp}, 32'd0);
        tick();
        IsEretCond = 1'b0;
        check("eret_exl", {31'd0, Exl}, 32'd0);
        check("refire", {31'd0, HasExp}, 32'd1);

        // Software exception wins over the pending interrupt
        SwExc = 1'b1; SwExcCode = 5'd8; PresentPC = 32'h0000_0100;
        tick();
        SwExc = 1'b0;
        check("sw_epc", EPC, 32'h0000_0100);
        rd(5'd13, "sw_cause", 32'h0000_0420);

        // SwExc while EXL=1 is ignored
        SwExc = 1'b1; SwExcCode = 5'd9; PresentPC = 32'h0000_0300;
        #1;
        check("nest_hasexp", {31'd0, HasExp}, 32'd0);
        tick();
        SwExc = 1'b0;
        check("nest_epc", EPC, 32'h0000_0100);
        rd(5'd13, "nest_cause", 32'h0000_0420);
        rd(5'd7, "addr7", 32'd0);

        // Leave handler with IE=0, then mtc0 EPC collides with SwExc
        Mtc0We = 1'b1; Cp0Addr = 5'd12; Cp0WData = 32'h0000_0400;
        tick();
        Mtc0We = 1'b0;
        check("ie0_exl", {31'd0, Exl}, 32'd0);
        check("ie0_hasexp", {31'd0, HasExp}, 32'd0);
        Mtc0We = 1'b1; Cp0Addr = 5'd14; Cp0WData = 32'hDEAD_BEEF;
        SwExc = 1'b1; SwExcCode = 5'd10; PresentPC = 32'h0000_0200;
        tick();
        Mtc0We = 1'b0; SwExc = 1'b0;
        check("mtc0_drop_epc", EPC, 32'h0000_0200);
        rd(5'd13, "ri_cause", 32'h0000_0428);

        Mtc0We = 1'b1; Cp0Addr = 5'd15; Cp0WData = 32'h0000_0055;
        tick();
        Mtc0We = 1'b0;
        rd(5'd15, "prid_ro", 32'h0000_0001);

        // Clear EXL, then set IE with interrupt pending
        Mtc0We = 1'b1; Cp0Addr = 5'd12; Cp0WData = 32'h0000_0400;
        tick();
        Cp0WData = 32'h0000_0401; PresentPC = 32'h0000_0500;
        #1;
        check("ie_set_same", {31'd0, HasExp}, 32'd0);
        tick();
        Mtc0We = 1'b0;
        check("ie_set_next", {31'd0, HasExp}, 32'd1);
        tick();
        check("handler_exl", {31'd0, Exl}, 32'd1);
        check("handler_epc", EPC, 32'h0000_0500);

        // Async reset in the middle of a handler
        Mtc0We = 1'b1; Cp0Addr = 5'd14; Cp0WData = 32'h0000_1234;
        tick();
        Mtc0We = 1'b0;
        check("pre_rst_epc", EPC, 32'h0000_1234);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_exl", {31'd0, Exl}, 32'd0);
        check("mid_rst_epc", EPC, 32'd0);
        check("mid_rst_hasexp", {31'd0, HasExp}, 32'd0);
        rd(5'd12, "mid_rst_status", 32'd0);
        #2;
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("post_rst_masked", {31'd0, HasExp}, 32'd0);
        rd(5'd13, "post_rst_ip", 32'h0000_0400);

        // IP follows the line: drop IntReq
        IntReq = '0;
        tick();
        tick();
        rd(5'd13, "ip_clear", 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception and interrupt controller for the single-cycle MIPS core. Holds Status, Cause, EPC and PRId and synchronises external interrupt lines. Decides each cycle whether the instruction at the current PC is pre-empted, and drives the `HasExp` / `EPC` inputs of the PC-select datapath. Also services `mtc0`/`mfc0` accesses and `eret`.

## Interface
- `PRID_VALUE`, 32'h0000_0001, read-only value returned for CP0 register 15
- `SYNC_STAGES`, 2, flop stages on each external interrupt line (allowed range 2..3)
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous and active-high
- `IntReq` in 6: external interrupt lines, asynchronous, level-sensitive
- `SwExc` in 1: decoded synchronous exception (syscall/break/reserved instruction) for the current instruction
- `SwExcCode` in 5: ExcCode to record with `SwExc`
- `IsEretCond` in 1: current instruction is `eret` (IsEret & IsCOP0)
- `Mtc0We` in 1: current instruction is `mtc0`
- `Cp0Addr` in 5: CP0 register number (rd field)
- `Cp0WData` in 32: `mtc0` write data (rt value)
- `PresentPC` in 32: PC of the current instruction
- `Cp0RData` out 32: `mfc0` read data, combinational from `Cp0Addr`
- `HasExp` out 1: pre-empt current instruction and redirect to 0x0000_0800
- `EPC` out 32: registered EPC, feeds the ERET path
- `Exl` out 1: Status.EXL, handler active

## Operation
- Registers:
  - Status (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): IP[15:10] (read-only), ExcCode[6:2]; other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): `PRID_VALUE`.
  - Any other address reads 0; writes to it are ignored.
- IP[5:0] = output of the `SYNC_STAGES`-deep synchroniser on `IntReq`, sampled every cycle. No latching: IP follows the line.
- `IntPend` = IE & ~EXL & |(IP & IM).
- `HasExp` = ~EXL & (SwExc | IntPend). It is combinational, so the core suppresses register/memory writes of the current instruction.
- On a rising edge with `HasExp`=1:
  - EPC <= `PresentPC`
  - ExcCode <= `SwExc` ? `SwExcCode` : 5'd0 (interrupt)
  - EXL <= 1
  - `SwExc` has priority over a simultaneous interrupt.
- On a rising edge with `IsEretCond`=1, EXL=1 and `HasExp`=0: EXL <= 0. The datapath loads PC from the current `EPC` value.
- `eret` with EXL=0: no state change.
- `Mtc0We`=1 and `HasExp`=0: write the addressed register.
  - Status: IM, EXL and IE are writable.
  - Cause: ExcCode only.
  - EPC: full 32 bits.
  - PRId: ignored.
- Simultaneous events:
  - `HasExp` together with `mtc0` or `eret`: the exception wins and the other operation is discarded.
  - `SwExc` while EXL=1: ignored, no nesting and no state change. The instruction completes normally (the core is responsible).
  - `mtc0` clearing EXL and `eret` in the same cycle: not encodable, since both come from one instruction.
- `mfc0` read is combinational and returns pre-edge values.

## Timing
- Reset (async, asserts immediately):
  - Status = 0 (IE=0, EXL=0, IM=0)
  - Cause = 0, EPC = 0, all synchroniser flops = 0
  - `HasExp` = 0, `Exl` = 0, `EPC` = 0, `Cp0RData` = 0 for addresses 12/13/14
- Reset assertion mid-handler drops EXL at once. On release, interrupts stay masked until software sets IE.
- Interrupt latency: an `IntReq` edge appears in IP `SYNC_STAGES` edges later. `HasExp` rises in that same cycle, combinationally, if enabled. EPC and EXL update on the next edge.
- `SwExc`: zero-cycle. `HasExp` in the same cycle; EPC and EXL update at the end of that cycle.
- After `mtc0` sets IE with an interrupt already pending, `HasExp` asserts in the following cycle.

## Structure
- Shared package `cp0_pkg`:
  - register numbers CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15
  - bit-field positions
  - ExcCode constants: INT=0, SYS=8, BP=9, RI=10
  - EXC_VECTOR=32'h0000_0800, shared with the PC-select logic
- Sub-module `int_sync`: parameterised multi-stage flop synchroniser with async reset, instantiated once for 6 bits.

## Test plan
- Reset asserted mid-cycle with EXL=1 and EPC=0x0000_1234 -> `Exl`, `EPC`, `HasExp` go to 0 immediately, before any clock edge.
- Status=0x0000_0401 (IM0, IE), `IntReq[0]` rises, `PresentPC`=0x0000_0040 -> `HasExp`=1 exactly 2 edges later. Next edge: EPC=0x0000_0040, ExcCode=0, EXL=1, `HasExp`=0.
- `SwExc`=1, `SwExcCode`=8 together with `IntReq` pending at `PresentPC`=0x0000_0100 -> ExcCode=8, EPC=0x0000_0100.
- EXL=1, EPC=0x0000_0104, `IsEretCond`=1 -> `EPC` output 0x0000_0104 during the cycle. EXL=0 after the edge. A held interrupt then re-fires the following cycle.
- `Mtc0We` to EPC with 0xDEAD_BEEF while `SwExc`=1 at PC 0x0000_0200 -> EPC=0x0000_0200 (write discarded). `Mtc0We` to PRId -> reads still `PRID_VALUE`.
- `SwExc`=1 while EXL=1 -> `HasExp`=0 and EPC unchanged. `mfc0` from address 7 -> 0.
